// File: rtl/vram_pkg.sv
// -----------------------------------------------------------------------------
// vram_pkg
// Shared constants for the VRAM responder slice.
// Contents:
//   VRAM_ADDR_W / VRAM_DATA_W : default SRAM word address / word width (RGB)
//   ST_*                      : responder FSM state encoding
//   CL_* / client_e           : client identifiers (bit positions in the
//                               one-hot client id, lowest index wins)
//   wait_count_init()         : converts a wait length into a counter preload
// -----------------------------------------------------------------------------
package vram_pkg;

    localparam int VRAM_ADDR_W = 20;
    localparam int VRAM_DATA_W = 24;

    // FSM encoding kept as plain constants so older tools see a simple vector.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_READ    = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_RECOVER = 2'd3;

    // Client identifiers. The numeric value is also the bit position in the
    // one-hot id, and lower numbers have higher arbitration priority.
    typedef enum logic [1:0] {
        CLIENT_DISP   = 2'd0,
        CLIENT_RND_RD = 2'd1,
        CLIENT_RND_WR = 2'd2
    } client_e;

    localparam int N_CLIENTS = 3;
    localparam int CL_DISP   = int'(CLIENT_DISP);
    localparam int CL_RND_RD = int'(CLIENT_RND_RD);
    localparam int CL_RND_WR = int'(CLIENT_RND_WR);

    typedef logic [N_CLIENTS-1:0] client_oh_t;

    // Counter preload: an access that must last w cycles counts w-1 .. 0.
    function automatic logic [3:0] wait_count_init(input int w);
        return 4'(w - 1);
    endfunction

endpackage

// File: rtl/vram_responder_if.sv
// -----------------------------------------------------------------------------
// vram_responder_if
// Bundles the renderer read/write ports, the scan-out read port and the SRAM
// pin-side signals of the VRAM responder.
//   slave  : the responder (consumes requests, drives data/strobes)
//   master : requesters plus the SRAM model / pad logic
// Parameters ADDR_W / DATA_W must match the responder instance.
// -----------------------------------------------------------------------------
interface vram_responder_if #(
    parameter int ADDR_W = vram_pkg::VRAM_ADDR_W,
    parameter int DATA_W = vram_pkg::VRAM_DATA_W
);
    // renderer read port
    logic [ADDR_W-1:0] i_rnd_read_address;
    logic              i_rnd_read_request;
    logic [DATA_W-1:0] o_rnd_read_data;
    logic              o_rnd_read_data_valid;
    // renderer write port
    logic [ADDR_W-1:0] i_rnd_write_address;
    logic [DATA_W-1:0] i_rnd_write_data;
    logic              i_rnd_write_request;
    logic              o_rnd_write_done;
    // scan-out read port
    logic [ADDR_W-1:0] i_disp_read_address;
    logic              i_disp_read_request;
    logic [DATA_W-1:0] o_disp_read_data;
    logic              o_disp_read_data_valid;
    // SRAM side
    logic [ADDR_W-1:0] o_sram_address;
    logic [DATA_W-1:0] o_sram_data_out;
    logic              o_sram_data_oe;
    logic [DATA_W-1:0] i_sram_data_in;
    logic              o_sram_ce_n;
    logic              o_sram_oe_n;
    logic              o_sram_we_n;

    modport slave (
        input  i_rnd_read_address, i_rnd_read_request,
        output o_rnd_read_data, o_rnd_read_data_valid,
        input  i_rnd_write_address, i_rnd_write_data, i_rnd_write_request,
        output o_rnd_write_done,
        input  i_disp_read_address, i_disp_read_request,
        output o_disp_read_data, o_disp_read_data_valid,
        output o_sram_address, o_sram_data_out, o_sram_data_oe,
        input  i_sram_data_in,
        output o_sram_ce_n, o_sram_oe_n, o_sram_we_n
    );

    modport master (
        output i_rnd_read_address, i_rnd_read_request,
        input  o_rnd_read_data, o_rnd_read_data_valid,
        output i_rnd_write_address, i_rnd_write_data, i_rnd_write_request,
        input  o_rnd_write_done,
        output i_disp_read_address, i_disp_read_request,
        input  o_disp_read_data, o_disp_read_data_valid,
        input  o_sram_address, o_sram_data_out, o_sram_data_oe,
        output i_sram_data_in,
        input  o_sram_ce_n, o_sram_oe_n, o_sram_we_n
    );

endinterface

// File: rtl/vram_port_arbiter.sv
// -----------------------------------------------------------------------------
// vram_port_arbiter
// Combinational fixed-priority arbiter. Bit 0 has the highest priority
// (scan-out read), then renderer read, then renderer write.
// Ports:
//   i_req         : request vector, one bit per client
//   o_grant_valid : at least one client requests
//   o_grant_oh    : one-hot id of the winning client (all zero when idle)
// -----------------------------------------------------------------------------
module vram_port_arbiter
    import vram_pkg::*;
(
    input  client_oh_t i_req,
    output logic       o_grant_valid,
    output client_oh_t o_grant_oh
);

    generate
        for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_grant
            if (gi == 0) begin : g_top
                assign o_grant_oh[gi] = i_req[gi];
            end else begin : g_lower
                // Wins only when no higher-priority client is asking.
                assign o_grant_oh[gi] = i_req[gi] & ~(|i_req[gi-1:0]);
            end
        end
    endgenerate

    assign o_grant_valid = |i_req;

endmodule

// File: rtl/vram_responder.sv
// -----------------------------------------------------------------------------
// vram_responder
// Serves renderer read/write requests and scan-out reads against one external
// asynchronous SRAM (one 24-bit word per pixel). Requests are levels sampled
// only in IDLE; each access runs IDLE -> READ|WRITE -> RECOVER -> IDLE.
// Ports:
//   i_master_clk : clock
//   i_reset      : synchronous, active-high reset (aborts any access)
//   bus          : request/response ports and SRAM pins (slave modport)
// Parameters:
//   ADDR_W, DATA_W : must match the interface instance
//   READ_WAIT      : cycles OE_n is held low before data is sampled (1..15)
//   WRITE_WAIT     : cycles WE_n is held low per write (1..15)
// -----------------------------------------------------------------------------
module vram_responder
    import vram_pkg::*;
#(
    parameter int ADDR_W     = VRAM_ADDR_W,
    parameter int DATA_W     = VRAM_DATA_W,
    parameter int READ_WAIT  = 2,
    parameter int WRITE_WAIT = 2
) (
    input  logic              i_master_clk,
    input  logic              i_reset,
    vram_responder_if.slave   bus
);

    localparam logic [3:0] RD_CNT_INIT = wait_count_init(READ_WAIT);
    localparam logic [3:0] WR_CNT_INIT = wait_count_init(WRITE_WAIT);

    client_oh_t req_vec;
    client_oh_t grant_oh;
    logic       grant_valid;

    assign req_vec[CL_DISP]   = bus.i_disp_read_request;
    assign req_vec[CL_RND_RD] = bus.i_rnd_read_request;
    assign req_vec[CL_RND_WR] = bus.i_rnd_write_request;

    vram_port_arbiter u_arbiter (
        .i_req         (req_vec),
        .o_grant_valid (grant_valid),
        .o_grant_oh    (grant_oh)
    );

    logic [1:0]        state_q,        state_d;
    logic [3:0]        cnt_q,          cnt_d;
    client_oh_t        client_q,       client_d;
    logic [ADDR_W-1:0] sram_addr_q,    sram_addr_d;
    logic [DATA_W-1:0] sram_dout_q,    sram_dout_d;
    logic              data_oe_q,      data_oe_d;
    logic              ce_n_q,         ce_n_d;
    logic              oe_n_q,         oe_n_d;
    logic              we_n_q,         we_n_d;
    logic [DATA_W-1:0] rnd_rdata_q,    rnd_rdata_d;
    logic [DATA_W-1:0] disp_rdata_q,   disp_rdata_d;
    logic              rnd_rvalid_q,   rnd_rvalid_d;
    logic              disp_rvalid_q,  disp_rvalid_d;
    logic              wr_done_q,      wr_done_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        client_d      = client_q;
        sram_addr_d   = sram_addr_q;
        sram_dout_d   = sram_dout_q;
        data_oe_d     = data_oe_q;
        ce_n_d        = ce_n_q;
        oe_n_d        = oe_n_q;
        we_n_d        = we_n_q;
        rnd_rdata_d   = rnd_rdata_q;
        disp_rdata_d  = disp_rdata_q;
        // completion flags are single-cycle pulses
        rnd_rvalid_d  = 1'b0;
        disp_rvalid_d = 1'b0;
        wr_done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    client_d = grant_oh;
                    ce_n_d   = 1'b0;
                    if (grant_oh[CL_RND_WR]) begin
                        state_d     = ST_WRITE;
                        cnt_d       = WR_CNT_INIT;
                        sram_addr_d = bus.i_rnd_write_address;
                        sram_dout_d = bus.i_rnd_write_data;
                        we_n_d      = 1'b0;
                        data_oe_d   = 1'b1;
                    end else begin
                        state_d     = ST_READ;
                        cnt_d       = RD_CNT_INIT;
                        sram_addr_d = grant_oh[CL_DISP] ? bus.i_disp_read_address
                                                        : bus.i_rnd_read_address;
                        oe_n_d      = 1'b0;
                    end
                end
            end

            ST_READ: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RECOVER;
                    oe_n_d  = 1'b1;
                    ce_n_d  = 1'b1;
                    // only the owning client's data register is updated
                    if (client_q[CL_DISP]) begin
                        disp_rdata_d  = bus.i_sram_data_in;
                        disp_rvalid_d = 1'b1;
                    end else if (client_q[CL_RND_RD]) begin
                        rnd_rdata_d   = bus.i_sram_data_in;
                        rnd_rvalid_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_WRITE: begin
                if (cnt_q == 4'd0) begin
                    state_d   = ST_RECOVER;
                    we_n_d    = 1'b1;
                    ce_n_d    = 1'b1;
                    wr_done_d = client_q[CL_RND_WR];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_RECOVER: begin
                // Address/data stay put for SRAM hold time; the bus is
                // released here so the next access starts from a quiet bus.
                state_d   = ST_IDLE;
                data_oe_d = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_master_clk) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 4'd0;
            client_q      <= '0;
            sram_addr_q   <= '0;
            sram_dout_q   <= '0;
            data_oe_q     <= 1'b0;
            ce_n_q        <= 1'b1;
            oe_n_q        <= 1'b1;
            we_n_q        <= 1'b1;
            rnd_rdata_q   <= '0;
            disp_rdata_q  <= '0;
            rnd_rvalid_q  <= 1'b0;
            disp_rvalid_q <= 1'b0;
            wr_done_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            client_q      <= client_d;
            sram_addr_q   <= sram_addr_d;
            sram_dout_q   <= sram_dout_d;
            data_oe_q     <= data_oe_d;
            ce_n_q        <= ce_n_d;
            oe_n_q        <= oe_n_d;
            we_n_q        <= we_n_d;
            rnd_rdata_q   <= rnd_rdata_d;
            disp_rdata_q  <= disp_rdata_d;
            rnd_rvalid_q  <= rnd_rvalid_d;
            disp_rvalid_q <= disp_rvalid_d;
            wr_done_q     <= wr_done_d;
        end
    end

    assign bus.o_rnd_read_data        = rnd_rdata_q;
    assign bus.o_rnd_read_data_valid  = rnd_rvalid_q;
    assign bus.o_rnd_write_done       = wr_done_q;
    assign bus.o_disp_read_data       = disp_rdata_q;
    assign bus.o_disp_read_data_valid = disp_rvalid_q;
    assign bus.o_sram_address         = sram_addr_q;
    assign bus.o_sram_data_out        = sram_dout_q;
    assign bus.o_sram_data_oe         = data_oe_q;
    assign bus.o_sram_ce_n            = ce_n_q;
    assign bus.o_sram_oe_n            = oe_n_q;
    assign bus.o_sram_we_n            = we_n_q;

endmodule

// File: tb/tb_vram_responder.sv
// -----------------------------------------------------------------------------
// tb_vram_responder
// Directed bench for vram_responder: a READ_WAIT=WRITE_WAIT=2 instance with a
// small SRAM model, plus a READ_WAIT=1 instance with a fixed-data SRAM.
// -----------------------------------------------------------------------------
module tb_vram_responder;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    vram_responder_if vif ();
    vram_responder_if vif1 ();

    vram_responder #(.READ_WAIT(2), .WRITE_WAIT(2)) dut (
        .i_master_clk (clk),
        .i_reset      (rst),
        .bus          (vif)
    );

    vram_responder #(.READ_WAIT(1), .WRITE_WAIT(2)) dut1 (
        .i_master_clk (clk),
        .i_reset      (rst),
        .bus          (vif1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: write while selected with WE_n low, combinational read.
    // A few locations are (re)loaded whenever reset is held.
    logic [23:0] mem [0:4095];

    always @(posedge clk) begin
        if (rst) begin
            mem[12'h777] <= 24'h0F0F0F;
            mem[12'h123] <= 24'hABCDEF;
            mem[12'h100] <= 24'h111111;
            mem[12'h200] <= 24'h222222;
        end else if (!vif.o_sram_ce_n && !vif.o_sram_we_n && vif.o_sram_data_oe) begin
            mem[vif.o_sram_address[11:0]] <= vif.o_sram_data_out;
        end
    end

    assign vif.i_sram_data_in  = (!vif.o_sram_ce_n && !vif.o_sram_oe_n)
                                 ? mem[vif.o_sram_address[11:0]] : 24'h000000;
    assign vif1.i_sram_data_in = (!vif1.o_sram_ce_n && !vif1.o_sram_oe_n)
                                 ? 24'h5A5A5A : 24'h000000;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [6:0] strobes;
        int ce_lo;
        rst = 1'b1;
        vif.i_disp_read_address = 20'h00777;
        vif.i_rnd_read_address  = 20'h00123;
        vif.i_rnd_write_address = 20'h00456;
        vif.i_rnd_write_data    = 24'h999999;
        vif.i_disp_read_request = 1'b1;
        vif.i_rnd_read_request  = 1'b1;
        vif.i_rnd_write_request = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            strobes = {vif.o_sram_ce_n, vif.o_sram_oe_n, vif.o_sram_we_n, vif.o_sram_data_oe,
                       vif.o_rnd_read_data_valid, vif.o_disp_read_data_valid, vif.o_rnd_write_done};
            checks++;
            if (strobes !== 7'b1110000) begin
                failures++;
                $display("FAIL reset_strobes cyc=%0d got=%b exp=1110000", c, strobes);
            end
        end
        checks++;
        if (vif.o_sram_address !== 20'h0 || vif.o_sram_data_out !== 24'h0 ||
            vif.o_rnd_read_data !== 24'h0 || vif.o_disp_read_data !== 24'h0) begin
            failures++;
            $display("FAIL reset_regs got addr=%h dout=%h rdata=%h ddata=%h exp all 0",
                     vif.o_sram_address, vif.o_sram_data_out, vif.o_rnd_read_data, vif.o_disp_read_data);
        end
        rst = 1'b0;
        step(); // accept edge: scan-out must win
        checks++;
        if (vif.o_sram_address !== 20'h00777 || vif.o_sram_oe_n !== 1'b0 || vif.o_sram_ce_n !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_grant got addr=%h oe_n=%b ce_n=%b exp addr=00777 oe_n=0 ce_n=0",
                     vif.o_sram_address, vif.o_sram_oe_n, vif.o_sram_ce_n);
        end
        vif.i_disp_read_request = 1'b0;
        vif.i_rnd_read_request  = 1'b0;
        vif.i_rnd_write_request = 1'b0;
        step();
        step();
        checks++;
        if (vif.o_disp_read_data_valid !== 1'b1 || vif.o_disp_read_data !== 24'h0F0F0F ||
            vif.o_rnd_read_data_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_disp_read got dvalid=%b ddata=%h rvalid=%b exp 1 0f0f0f 0",
                     vif.o_disp_read_data_valid, vif.o_disp_read_data, vif.o_rnd_read_data_valid);
        end
        ce_lo = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (!vif.o_sram_ce_n) ce_lo++;
        end
        checks++;
        if (ce_lo !== 0) begin
            failures++;
            $display("FAIL reset_no_reserve got ce_low_cycles=%0d exp 0", ce_lo);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_read();
        int lat = -1;
        int oe_lo = 0;
        int nval = 0;
        logic [23:0] got = 24'h0;
        vif.i_rnd_read_address = 20'h00123;
        vif.i_rnd_read_request = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (!vif.o_sram_oe_n) oe_lo++;
            if (vif.o_rnd_read_data_valid) begin
                nval++;
                if (lat < 0) lat = c;
                got = vif.o_rnd_read_data;
                vif.i_rnd_read_request = 1'b0;
            end
        end
        vif.i_rnd_read_request = 1'b0;
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL read_latency got=%0d exp=3", lat); end
        checks++;
        if (oe_lo !== 2) begin failures++; $display("FAIL read_oe_low got=%0d exp=2", oe_lo); end
        checks++;
        if (nval !== 1) begin failures++; $display("FAIL read_pulses got=%0d exp=1", nval); end
        checks++;
        if (got !== 24'hABCDEF) begin failures++; $display("FAIL read_data got=%h exp=abcdef", got); end
        checks++;
        if (vif.o_disp_read_data !== 24'h0F0F0F) begin
            failures++;
            $display("FAIL read_disp_untouched got=%h exp=0f0f0f", vif.o_disp_read_data);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_write();
        int lat = -1;
        int we_lo = 0;
        int doe_hi = 0;
        int ndone = 0;
        vif.i_rnd_write_address = 20'h00456;
        vif.i_rnd_write_data    = 24'h123456;
        vif.i_rnd_write_request = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (!vif.o_sram_we_n) we_lo++;
            if (vif.o_sram_data_oe) doe_hi++;
            if (vif.o_rnd_write_done) begin
                ndone++;
                if (lat < 0) lat = c;
                vif.i_rnd_write_request = 1'b0;
            end
        end
        vif.i_rnd_write_request = 1'b0;
        checks++;
        if (we_lo !== 2) begin failures++; $display("FAIL write_we_low got=%0d exp=2", we_lo); end
        checks++;
        if (doe_hi !== 3) begin failures++; $display("FAIL write_data_oe got=%0d exp=3", doe_hi); end
        checks++;
        if (ndone !== 1) begin failures++; $display("FAIL write_pulses got=%0d exp=1", ndone); end
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL write_latency got=%0d exp=3", lat); end
        checks++;
        if (mem[12'h456] !== 24'h123456) begin
            failures++;
            $display("FAIL write_sram got=%h exp=123456", mem[12'h456]);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        int ev_type [8];
        int ev_cyc  [8];
        int nev = 0;
        logic [23:0] dgot = 24'h0;
        logic [23:0] rgot = 24'h0;
        vif.i_disp_read_address = 20'h00100;
        vif.i_rnd_read_address  = 20'h00200;
        vif.i_rnd_write_address = 20'h00300;
        vif.i_rnd_write_data    = 24'h333333;
        vif.i_disp_read_request = 1'b1;
        vif.i_rnd_read_request  = 1'b1;
        vif.i_rnd_write_request = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (vif.o_disp_read_data_valid && nev < 8) begin
                ev_type[nev] = 0; ev_cyc[nev] = c; nev++;
                dgot = vif.o_disp_read_data;
                vif.i_disp_read_request = 1'b0;
            end
            if (vif.o_rnd_read_data_valid && nev < 8) begin
                ev_type[nev] = 1; ev_cyc[nev] = c; nev++;
                rgot = vif.o_rnd_read_data;
                vif.i_rnd_read_request = 1'b0;
            end
            if (vif.o_rnd_write_done && nev < 8) begin
                ev_type[nev] = 2; ev_cyc[nev] = c; nev++;
                vif.i_rnd_write_request = 1'b0;
            end
        end
        vif.i_disp_read_request = 1'b0;
        vif.i_rnd_read_request  = 1'b0;
        vif.i_rnd_write_request = 1'b0;
        checks++;
        if (nev !== 3) begin
            failures++;
            $display("FAIL b2b_pulse_count got=%0d exp=3", nev);
        end else begin
            checks++;
            if (ev_type[0] !== 0 || ev_type[1] !== 1 || ev_type[2] !== 2) begin
                failures++;
                $display("FAIL b2b_order got=%0d,%0d,%0d exp=0,1,2", ev_type[0], ev_type[1], ev_type[2]);
            end
            checks++;
            if (ev_cyc[0] !== 3 || ev_cyc[1] - ev_cyc[0] !== 4 || ev_cyc[2] - ev_cyc[1] !== 4) begin
                failures++;
                $display("FAIL b2b_spacing got cyc=%0d,%0d,%0d exp=3,7,11", ev_cyc[0], ev_cyc[1], ev_cyc[2]);
            end
        end
        checks++;
        if (dgot !== 24'h111111) begin failures++; $display("FAIL b2b_disp_data got=%h exp=111111", dgot); end
        checks++;
        if (rgot !== 24'h222222) begin failures++; $display("FAIL b2b_rnd_data got=%h exp=222222", rgot); end
        checks++;
        if (mem[12'h300] !== 24'h333333) begin
            failures++;
            $display("FAIL b2b_write_sram got=%h exp=333333", mem[12'h300]);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_hold_after_done();
        int we_lo = 0;
        int ndone = 0;
        bit drop_pending = 0;
        vif.i_rnd_write_address = 20'h00500;
        vif.i_rnd_write_data    = 24'h0A0B0C;
        vif.i_rnd_write_request = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            step();
            if (!vif.o_sram_we_n) we_lo++;
            if (drop_pending) begin
                vif.i_rnd_write_request = 1'b0;
                drop_pending = 0;
            end
            if (vif.o_rnd_write_done) begin
                ndone++;
                drop_pending = 1;
            end
        end
        vif.i_rnd_write_request = 1'b0;
        checks++;
        if (ndone !== 1 || we_lo !== 2) begin
            failures++;
            $display("FAIL hold_single_write got done=%0d we_low=%0d exp done=1 we_low=2", ndone, we_lo);
        end
        checks++;
        if (mem[12'h500] !== 24'h0A0B0C) begin
            failures++;
            $display("FAIL hold_write_sram got=%h exp=0a0b0c", mem[12'h500]);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_write();
        int ndone = 0;
        vif.i_rnd_write_address = 20'h00600;
        vif.i_rnd_write_data    = 24'h666666;
        vif.i_rnd_write_request = 1'b1;
        step();                 // accept edge: write cycle 1
        checks++;
        if (vif.o_sram_we_n !== 1'b0) begin
            failures++;
            $display("FAIL abort_write_started got we_n=%b exp=0", vif.o_sram_we_n);
        end
        step();                 // write cycle 2
        rst = 1'b1;
        step();
        checks++;
        if ({vif.o_sram_we_n, vif.o_sram_ce_n, vif.o_sram_data_oe, vif.o_rnd_write_done} !== 4'b1100) begin
            failures++;
            $display("FAIL abort_strobes got we_n=%b ce_n=%b data_oe=%b done=%b exp 1 1 0 0",
                     vif.o_sram_we_n, vif.o_sram_ce_n, vif.o_sram_data_oe, vif.o_rnd_write_done);
        end
        rst = 1'b0;
        vif.i_rnd_write_data = 24'h676767;  // re-request with fresh data
        for (int c = 1; c <= 12; c++) begin
            step();
            if (vif.o_rnd_write_done) begin
                ndone++;
                vif.i_rnd_write_request = 1'b0;
            end
        end
        vif.i_rnd_write_request = 1'b0;
        checks++;
        if (ndone !== 1) begin failures++; $display("FAIL abort_rerequest_done got=%0d exp=1", ndone); end
        checks++;
        if (mem[12'h600] !== 24'h676767) begin
            failures++;
            $display("FAIL abort_rerequest_sram got=%h exp=676767", mem[12'h600]);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_read_wait1();
        int lat = -1;
        int oe_lo = 0;
        int nval = 0;
        logic [23:0] got = 24'h0;
        vif1.i_rnd_read_address = 20'h00042;
        vif1.i_rnd_read_request = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (!vif1.o_sram_oe_n) oe_lo++;
            if (vif1.o_rnd_read_data_valid) begin
                nval++;
                if (lat < 0) lat = c;
                got = vif1.o_rnd_read_data;
                vif1.i_rnd_read_request = 1'b0;
            end
        end
        vif1.i_rnd_read_request = 1'b0;
        checks++;
        if (lat !== 2 || oe_lo !== 1) begin
            failures++;
            $display("FAIL rw1_timing got latency=%0d oe_low=%0d exp latency=2 oe_low=1", lat, oe_lo);
        end
        checks++;
        if (nval !== 1 || got !== 24'h5A5A5A) begin
            failures++;
            $display("FAIL rw1_data got pulses=%0d data=%h exp pulses=1 data=5a5a5a", nval, got);
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        vif.i_rnd_read_address   = '0;
        vif.i_rnd_read_request   = 1'b0;
        vif.i_rnd_write_address  = '0;
        vif.i_rnd_write_data     = '0;
        vif.i_rnd_write_request  = 1'b0;
        vif.i_disp_read_address  = '0;
        vif.i_disp_read_request  = 1'b0;
        vif1.i_rnd_read_address  = '0;
        vif1.i_rnd_read_request  = 1'b0;
        vif1.i_rnd_write_address = '0;
        vif1.i_rnd_write_data    = '0;
        vif1.i_rnd_write_request = 1'b0;
        vif1.i_disp_read_address = '0;
        vif1.i_disp_read_request = 1'b0;

        test_reset();
        repeat (2) step();
        test_single_read();
        repeat (2) step();
        test_single_write();
        repeat (2) step();
        test_back_to_back();
        repeat (2) step();
        test_hold_after_done();
        repeat (2) step();
        test_reset_mid_write();
        repeat (2) step();
        test_read_wait1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
